// File: rtl/systolic_pkg.sv
// Shared definitions for the N x N output-stationary systolic multiplier:
// controller state encoding and the width helpers used by the top level.
package systolic_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Bits needed to hold an inner dimension in 0..kmax.
  function automatic int k_len_w(input int kmax);
    return $clog2(kmax + 1);
  endfunction

  // Bits needed for a row index 0..n-1.
  function automatic int row_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Zero-injection cycles after the last operand beat: 2N-2 cycles of skew
  // plus one PE register stage.
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

  // Bits for the flush counter, which runs 0..flush_cycles(n)-1.
  function automatic int flush_w(input int n);
    return $clog2(flush_cycles(n));
  endfunction

endpackage

// File: rtl/systolic_pe_acc.sv
// One processing element: forwards a (east) and b (south) through one
// register each and accumulates a*b into an ACC_WIDTH accumulator.
// Build option: define SYSTOLIC_SIGNED_EN for two's complement operands;
// otherwise operands and products are unsigned.
module systolic_pe_acc #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic [ACC_WIDTH-1:0] acc
);

  logic [ACC_WIDTH-1:0] prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
  logic signed [2*WIDTH-1:0] prod;
  assign prod     = $signed(a_in) * $signed(b_in);
  // Signed cast sign-extends the product to the accumulator width.
  assign prod_ext = ACC_WIDTH'(prod);
`else
  logic [2*WIDTH-1:0] prod;
  assign prod     = a_in * b_in;
  assign prod_ext = ACC_WIDTH'(prod);
`endif

  // Forward operands one hop and accumulate; clr wins over accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic matrix multiplier (C = A x B).
// Holds the job controller, input skew lines, the PE grid and the row drain.
// Build option: SYSTOLIC_SIGNED_EN selects signed arithmetic inside the PEs.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Operand side: in_ready is high only in LOAD and does not depend on
// in_valid. Result side: out_valid does not depend on out_ready; while
// out_valid && !out_ready, out_data/out_row/out_last hold their values.
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int KMAX      = 16,
  parameter int ACC_WIDTH = 2 * WIDTH + $clog2(KMAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*WIDTH-1:0]       a_col,
  input  logic [N*WIDTH-1:0]       b_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*ACC_WIDTH-1:0]   out_data,
  output logic [$clog2(N)-1:0]     out_row,
  output logic                     out_last,
  output logic                     done
);

  localparam int KW = k_len_w(KMAX);
  localparam int RW = row_w(N);
  localparam int FW = flush_w(N);
  localparam logic [KW-1:0] KMAX_K     = KW'(KMAX);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(flush_cycles(N) - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

  state_t              state;
  logic [KW-1:0]       k_lat;
  logic [KW-1:0]       beat_cnt;
  logic [FW-1:0]       flush_cnt;
  logic [RW-1:0]       row_q;
  logic                done_q;
  logic [KW-1:0]       k_clamp;
  logic                start_ok;
  logic                beat;
  logic                last_take;
  logic [ACC_WIDTH-1:0] acc [N][N];

  // A start in the done cycle is ignored even though the state is IDLE.
  assign start_ok  = (state == ST_IDLE) && start && !done_q;
  assign k_clamp   = (k_len > KMAX_K) ? KMAX_K : k_len;
  assign beat      = (state == ST_LOAD) && in_valid;
  assign last_take = (state == ST_DRAIN) && out_ready && (row_q == ROW_LAST);

  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_DRAIN);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == ROW_LAST);
  assign done      = done_q;

  // Job controller: IDLE -> LOAD (k beats) -> FLUSH (2N-1) -> DRAIN (N rows).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= last_take;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            k_lat     <= k_clamp;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_q     <= '0;
            state     <= (k_clamp == '0) ? ST_FLUSH : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_lat - KW'(1)) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= ST_DRAIN;
            row_q <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (row_q == ROW_LAST) begin
              state <= ST_IDLE;
              row_q <= '0;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Edge injection and skew: lane i is delayed i cycles; idle lanes carry zero.
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [WIDTH-1:0] a_inj;
    logic [WIDTH-1:0] b_inj;
    logic [WIDTH-1:0] a_edge;
    logic [WIDTH-1:0] b_edge;
    assign a_inj = beat ? a_col[i*WIDTH +: WIDTH] : '0;
    assign b_inj = beat ? b_row[i*WIDTH +: WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_edge = a_inj;
      assign b_edge = b_inj;
    end else begin : g_delay
      logic [WIDTH-1:0] a_sr [i];
      logic [WIDTH-1:0] b_sr [i];
      // Shift lines of depth i for A row i and B column i.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < i; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_inj;
          b_sr[0] <= b_inj;
          for (int d = 1; d < i; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end
      assign a_edge = a_sr[i-1];
      assign b_edge = b_sr[i-1];
    end
  end

  // PE grid: a flows east along rows, b flows south along columns.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [WIDTH-1:0] pe_a;
      logic [WIDTH-1:0] pe_b;
      logic [WIDTH-1:0] a_fwd;
      logic [WIDTH-1:0] b_fwd;
      if (j == 0) begin : g_a_edge
        assign pe_a = g_skew[i].a_edge;
      end else begin : g_a_link
        assign pe_a = g_row[i].g_col[j-1].a_fwd;
      end
      if (i == 0) begin : g_b_edge
        assign pe_b = g_skew[j].b_edge;
      end else begin : g_b_link
        assign pe_b = g_row[i-1].g_col[j].b_fwd;
      end
      if (j == N - 1) begin : g_a_tail
        logic [WIDTH-1:0] unused_a;
        assign unused_a = a_fwd;
      end
      if (i == N - 1) begin : g_b_tail
        logic [WIDTH-1:0] unused_b;
        assign unused_b = b_fwd;
      end
      systolic_pe_acc #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .a_in (pe_a),
        .b_in (pe_b),
        .a_out(a_fwd),
        .b_out(b_fwd),
        .acc  (acc[i][j])
      );
    end
  end

  // Drain mux: present accumulator row out_row while draining, zero otherwise.
  for (genvar j = 0; j < N; j++) begin : g_drain
    assign out_data[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row_q][j] : '0;
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// Self-checking bench for systolic_array_nxn (N=4, WIDTH=8, KMAX=16).
// Expected rows come from a plain matrix-product model over the same operand
// tables the driver streams; a negedge monitor checks every drained row.
module tb_systolic_array_nxn;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int KMAX = 16;
  localparam int AW   = 2 * W + $clog2(KMAX);
  localparam int KW   = $clog2(KMAX + 1);
  localparam int RW   = $clog2(N);
  localparam int DW   = N * AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*W-1:0] a_col = '0;
  logic [N*W-1:0] b_row = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic          done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_left = 0;

  logic [DW-1:0] exp_q[$];
  logic [W-1:0]  am [N][KMAX];
  logic [W-1:0]  bm [KMAX][N];

  systolic_array_nxn #(
    .N(N), .WIDTH(W), .KMAX(KMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_row  (out_row),
    .out_last (out_last),
    .done     (done)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] row4(input int c0, input int c1, input int c2, input int c3);
    return {AW'(c3), AW'(c2), AW'(c1), AW'(c0)};
  endfunction

  // Model: C[r][j] = sum_t A[r][t]*B[t][j], kept to AW bits.
  function automatic longint mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SYSTOLIC_SIGNED_EN
    return longint'($signed(a)) * longint'($signed(b));
`else
    return longint'(a) * longint'(b);
`endif
  endfunction

  function automatic logic [DW-1:0] model_row(input int r, input int k);
    logic [DW-1:0] row;
    longint s;
    row = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int t = 0; t < k; t++) s += mul(am[r][t], bm[t][j]);
      row[j*AW +: AW] = AW'(s);
    end
    return row;
  endfunction

  task automatic clear_mats();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KMAX; t++) begin
        am[i][t] = '0;
        bm[t][i] = '0;
      end
  endtask

  task automatic drive_beat(input int t);
    for (int i = 0; i < N; i++) begin
      a_col[i*W +: W] = am[i][t];
      b_row[i*W +: W] = bm[t][i];
    end
  endtask

  task automatic drive_garbage();
    a_col = {N{8'hA5}};
    b_row = {N{8'h5A}};
  endtask

  // Downstream: accept everything except a stall_left-cycle hold on row 1.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (out_valid && stall_left > 0 && out_row == RW'(1)) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Scoreboard monitor: rows, row index, last flag, stall stability, done.
  logic [DW-1:0] prev_data;
  logic [RW-1:0] prev_row;
  bit prev_stall = 1'b0;
  bit hs_last_prev = 1'b0;
  bit hs_last;
  int exp_row = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall   = 1'b0;
      hs_last_prev = 1'b0;
      exp_row      = 0;
    end else begin
      hs_last = 1'b0;
      check("done", done, hs_last_prev);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_extra", out_valid, 0);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_row", out_row, exp_row);
          check("out_last", out_last, exp_row == N - 1);
        end
        if (prev_stall) begin
          check("stall_data", out_data, prev_data);
          check("stall_row", out_row, prev_row);
        end
        if (out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs_last = (exp_row == N - 1);
          exp_row = (exp_row + 1) % N;
        end
      end
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_row     = out_row;
      hs_last_prev = hs_last;
    end
  end

  // Driver: one complete job, with optional bubbles, row-1 stall and start pokes.
  task automatic run_job(input int k, input bit bubbles, input int stall_n, input bit poke);
    int keff;
    int load_cyc;
    int n;
    keff = (k > KMAX) ? KMAX : k;
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(k);
    for (int r = 0; r < N; r++) exp_q.push_back(model_row(r, keff));
    stall_left = stall_n;
    @(posedge clk); #1;
    start = 1'b0;
    load_cyc = cyc;
    check("busy_job", busy, 1);
    for (int t = 0; t < keff; t++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        drive_garbage();
        check("in_ready_bubble", in_ready, 1);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      drive_beat(t);
      check("in_ready_load", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drive_garbage();
    check("in_ready_after_load", in_ready, 0);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_valid_seen", out_valid, 1);
    if (!bubbles) check("latency", cyc - load_cyc, keff + 2 * N - 1);
    if (poke) begin
      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    if (poke) begin
      start = 1'b1;
      k_len = KW'(3);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("start_ignored_busy", busy, 0);
      check("start_ignored_ready", in_ready, 0);
    end
    check("rows_left", exp_q.size(), 0);
  endtask

  task automatic set_identity();
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 2; t++) am[i][t] = W'(2 * i + t + 1);
    bm[0][0] = 8'd1;
    bm[1][1] = 8'd1;
  endtask

  // Watchdog
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    rst = 1'b1;

    // Identity-style job, k=2
    set_identity();
    check("pin_id_r0", model_row(0, 2), row4(1, 2, 0, 0));
    check("pin_id_r3", model_row(3, 2), row4(7, 8, 0, 0));
    run_job(2, 1'b0, 0, 1'b0);

    // Same job with bubbles on alternate cycles
    run_job(2, 1'b1, 0, 1'b0);

    // All 255, k=4
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 4; t++) begin
        am[i][t] = 8'hFF;
        bm[t][i] = 8'hFF;
      end
    check("pin_255", model_row(2, 4), row4(260100, 260100, 260100, 260100));
    run_job(4, 1'b0, 0, 1'b0);

    // Backpressure at row 1 for 5 cycles, k=3
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < 3; t++) begin
        am[i][t] = W'(i + t + 1);
        bm[t][i] = W'(i + 2 * t + 1);
      end
    check("pin_bp_r0", model_row(0, 3), row4(22, 28, 34, 40));
    run_job(3, 1'b0, 5, 1'b0);

    // k=0 gives zero rows; start pulses during DRAIN and at done are ignored
    clear_mats();
    for (int i = 0; i < N; i++) am[i][0] = 8'd9;
    run_job(0, 1'b0, 0, 1'b1);

    // k_len above KMAX is clamped
    clear_mats();
    for (int i = 0; i < N; i++)
      for (int t = 0; t < KMAX; t++) begin
        am[i][t] = W'(200 + 13 * i + 5 * t);
        bm[t][i] = W'(17 + 31 * t + 7 * i);
      end
    run_job(20, 1'b0, 0, 1'b0);

    // Reset mid-LOAD aborts the job
    @(posedge clk); #1;
    start = 1'b1;
    k_len = KW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    drive_beat(0);
    @(posedge clk); #1;
    drive_beat(1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    set_identity();
    run_job(2, 1'b0, 0, 1'b0);

`ifdef SYSTOLIC_SIGNED_EN
    // Signed operands, k=1
    clear_mats();
    am[0][0] = 8'hFF;
    am[1][0] = 8'd2;
    bm[0][0] = 8'd3;
    bm[0][1] = 8'hFC;
    check("pin_signed_r0", model_row(0, 1), row4(-3, 4, 0, 0));
    check("pin_signed_r1", model_row(1, 1), row4(6, -8, 0, 0));
    run_job(1, 1'b0, 0, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_nxn.md
Name: systolic_array_nxn

Overview:
- Parametrised N×N output-stationary systolic matrix multiplier; successor to the fixed 2×2 array.
- Computes C = A×B, with A of size N×k_len and B of size k_len×N, streamed one inner-dimension beat per cycle.
- Adds on top of the 2×2 array: internal input skew, a run-length controller FSM, accumulator clear on start, and a backpressured row-by-row result drain.
- Sits between the operand buffers and the result writeback path of the accelerator.

Parameters:
- N, 4, array dimension (rows = cols), ≥2.
- WIDTH, 8, operand width.
- KMAX, 16, maximum inner dimension per job.
- ACC_WIDTH, 2*WIDTH+$clog2(KMAX), accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- k_len  in  $clog2(KMAX+1)  inner dimension, sampled with start.
- busy  out  1  high whenever state ≠ IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- a_col  in  N*WIDTH  A[i][t] in slice i.
- b_row  in  N*WIDTH  B[t][j] in slice j.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accept.
- out_data  out  N*ACC_WIDTH  C[r][j] in slice j.
- out_row  out  $clog2(N)  row index r of out_data.
- out_last  out  1  high with row N-1.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; all accumulators, skew registers and PE pipeline registers cleared; outputs busy=0, in_ready=0, out_valid=0, out_data=0, out_row=0, out_last=0, done=0.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE
  - start=1 with k_len≥1: clear all accumulators, latch k_len, go to LOAD.
  - start=1 with k_len=0: clear all accumulators, go directly to FLUSH; the result is all zeros.
  - k_len>KMAX is clamped to KMAX.
- LOAD
  - in_ready=1. A beat counts when in_valid&in_ready; LOAD ends after k_len counted beats, then go to FLUSH.
  - Cycles with in_valid=0 inject zeros into both the A and B edges. Zero beats add nothing, so the array never stalls.
- Skew
  - Row i of A is delayed i cycles before entering column 0.
  - Column j of B is delayed j cycles before entering row 0.
  - Each PE registers a and b forward (1 cycle) and accumulates acc += a*b.
- FLUSH
  - Zeros are injected for exactly 2N-1 cycles, which covers the 2N-2 skew plus the PE register. Then go to DRAIN with row index 0.
- DRAIN
  - out_valid=1; out_data shows accumulator row out_row.
  - out_data, out_row and out_last are held stable while out_valid&!out_ready.
  - On handshake, out_row increments. After row N-1 is accepted: done=1 for one cycle, go to IDLE, out_valid=0.
  - out_valid falls in the same cycle the last handshake completes.
- Arithmetic
  - Unsigned by default; products are 2*WIDTH bits, zero-extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH.
- start outside IDLE is ignored, including when it coincides with the done cycle.
- Reset asserted mid-job aborts immediately. No done pulse is issued, and accumulators read 0 afterwards.
- Latency: the first out_valid appears k_len+2N-1 cycles after the LOAD entry cycle, with in_valid held high and k_len≥1.

Optional Feature:
- Macro: SYSTOLIC_SIGNED_EN.
- Defined: operands are two's complement; products and accumulators are signed, sign-extended to ACC_WIDTH, wrapping on overflow.
- Undefined: all arithmetic is unsigned as described above.
- Port list is identical in both builds.

Decomposition:
- Package systolic_pkg:
  - state enum (IDLE/LOAD/FLUSH/DRAIN);
  - width helper functions/constants: clog2-based widths for k_len, out_row and the flush counter;
  - FLUSH_CYCLES(N)=2N-1 constant function.
- Sub-module systolic_pe_acc: one PE with clr input, forwarded a/b registers, and ACC_WIDTH accumulator. It holds the signed/unsigned selection under SYSTOLIC_SIGNED_EN.
- Top level holds the FSM, counters, skew shift registers, N×N generate grid and drain mux.

Test Plan:
- Identity (N=2, k_len=2): A=[[1,2],[3,4]], B=I → rows out [1,2] then [3,4]; out_last on row 1; one done pulse.
- Default build (N=4, k_len=4): A=all 255, B=all 255 → every C entry = 4*65025 = 260100, which fits in 20 bits.
- Bubbles: same job as the identity test with in_valid low on alternate cycles → identical results; LOAD lasts until the 2nd accepted beat.
- Backpressure: out_ready low for 5 cycles at row 1 → out_data/out_row stable during the stall; row order preserved.
- k_len=0 → all-zero rows. Also drive start during DRAIN → ignored. Also assert rst mid-LOAD → busy=0 immediately; the next job's result is uncorrupted.
- SYSTOLIC_SIGNED_EN (N=2, k_len=1): a=[-1,2], b=[3,-4] → rows [-3,4] then [6,-8].
